// File: rtl/hazard_if.sv
// Hazard controller bus: ID-stage decode fields and MEM-stage status in,
// stall / flush / forwarding controls and event counters out.
interface hazard_if;
  localparam int unsigned REG_W = 4;
  localparam int unsigned WB_W  = 2;
  localparam int unsigned CNT_W = 16;

  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic [REG_W-1:0] id_rd;
  logic [WB_W-1:0]  id_wb;
  logic             mem_branch_taken;
  logic             mem_wait;

  logic             pc_stall;
  logic             ifid_stall;
  logic             idex_bubble;
  logic             flush_ifid;
  logic             flush_idex;
  logic             flush_exmem;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_wb,
           mem_branch_taken, mem_wait,
    input  pc_stall, ifid_stall, idex_bubble, flush_ifid, flush_idex,
           flush_exmem, fwd_a, fwd_b, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_wb,
           mem_branch_taken, mem_wait,
    output pc_stall, ifid_stall, idex_bubble, flush_ifid, flush_idex,
           flush_exmem, fwd_a, fwd_b, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks EX/MEM/WB writers, detects load-use,
// sequences stall and branch flush, and selects EX operand forwarding.
module hazard_ctrl (
  input  logic     clk,
  input  logic     rst_n,
  hazard_if.slave  hz
);
  localparam int unsigned REG_W = 4;
  localparam int unsigned WB_W  = 2;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_e;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             use_rs;
    logic             use_rt;
    logic [WB_W-1:0]  wb;
  } ex_ent_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic [WB_W-1:0]  wb;
  } wr_ent_t;

  state_e           state_q, state_d;
  ex_ent_t          ex_q, ex_d;
  wr_ent_t          mem_q, mem_d, wb_q, wb_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             load_use_c;
  logic             stall_inc_c, flush_inc_c;
  logic             pc_stall_c, ifid_stall_c, idex_bubble_c, flush_c;

  // Operand source: MEM-stage ALU result first, then anything writing back.
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                         input logic use_src,
                                         input wr_ent_t mem,
                                         input wr_ent_t wb);
    fwd_sel = 2'b00;
    if (use_src && src != '0) begin
      if (mem.valid && mem.wb == 2'b01 && mem.rd == src)
        fwd_sel = 2'b01;
      else if (wb.valid && wb.wb[0] && wb.rd == src)
        fwd_sel = 2'b10;
    end
  endfunction

  always_comb begin
    load_use_c = ex_q.valid && ex_q.wb == 2'b11 && ex_q.rd != '0 && hz.id_valid &&
                 ((hz.id_use_rs && hz.id_rs == ex_q.rd) ||
                  (hz.id_use_rt && hz.id_rt == ex_q.rd));
  end

  // Next state, scoreboard shift and stall/flush controls.
  always_comb begin
    state_d       = state_q;
    ex_d.valid    = hz.id_valid;
    ex_d.rd       = hz.id_rd;
    ex_d.rs       = hz.id_rs;
    ex_d.rt       = hz.id_rt;
    ex_d.use_rs   = hz.id_use_rs;
    ex_d.use_rt   = hz.id_use_rt;
    ex_d.wb       = hz.id_wb;
    mem_d.valid   = ex_q.valid;
    mem_d.rd      = ex_q.rd;
    mem_d.wb      = ex_q.wb;
    wb_d          = mem_q;
    stall_inc_c   = 1'b0;
    flush_inc_c   = 1'b0;
    pc_stall_c    = 1'b0;
    ifid_stall_c  = 1'b0;
    idex_bubble_c = 1'b0;
    flush_c       = 1'b0;

    if (hz.mem_wait) begin
      ex_d         = ex_q;
      mem_d        = mem_q;
      wb_d         = wb_q;
      pc_stall_c   = 1'b1;
      ifid_stall_c = 1'b1;
    end else begin
      unique case (state_q)
        RUN, STALL: begin
          state_d = RUN;
          if (hz.mem_branch_taken) begin
            state_d     = FLUSH;
            ex_d        = '0;
            mem_d       = '0;
            flush_c     = 1'b1;
            flush_inc_c = 1'b1;
          end else if (state_q == RUN && load_use_c) begin
            state_d       = STALL;
            ex_d          = '0;
            pc_stall_c    = 1'b1;
            ifid_stall_c  = 1'b1;
            idex_bubble_c = 1'b1;
            stall_inc_c   = 1'b1;
          end
        end
        FLUSH: begin
          state_d = RUN;
          ex_d    = '0;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      if (stall_inc_c && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_inc_c && flush_cnt_q != '1)
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  // Controls are forced low while reset is held, whatever the inputs do.
  assign hz.pc_stall    = rst_n & pc_stall_c;
  assign hz.ifid_stall  = rst_n & ifid_stall_c;
  assign hz.idex_bubble = rst_n & idex_bubble_c;
  assign hz.flush_ifid  = rst_n & flush_c;
  assign hz.flush_idex  = rst_n & flush_c;
  assign hz.flush_exmem = rst_n & flush_c;
  assign hz.fwd_a       = rst_n ? fwd_sel(ex_q.rs, ex_q.use_rs, mem_q, wb_q) : 2'b00;
  assign hz.fwd_b       = rst_n ? fwd_sel(ex_q.rt, ex_q.use_rt, mem_q, wb_q) : 2'b00;
  assign hz.stall_cnt   = stall_cnt_q;
  assign hz.flush_cnt   = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use stall, forwarding, branch flush,
// memory wait freeze, r0 handling, counter saturation and reset abort.
module tb_hazard_ctrl;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  hazard_if hz ();

  hazard_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz.slave)
  );

  logic [2:0] stl;
  logic [2:0] fl;
  assign stl = {hz.pc_stall, hz.ifid_stall, hz.idex_bubble};
  assign fl  = {hz.flush_ifid, hz.flush_idex, hz.flush_exmem};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_id(input logic v, input logic [3:0] rs, input logic [3:0] rt,
                          input logic urs, input logic urt, input logic [3:0] rd,
                          input logic [1:0] wb);
    hz.id_valid  = v;
    hz.id_rs     = rs;
    hz.id_rt     = rt;
    hz.id_use_rs = urs;
    hz.id_use_rt = urt;
    hz.id_rd     = rd;
    hz.id_wb     = wb;
  endtask

  task automatic drive_nop();
    drive_id(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 2'b00);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    hz.mem_branch_taken = 1'b0;
    hz.mem_wait = 1'b0;
    drive_nop();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    hz.mem_branch_taken = 1'b1;
    hz.mem_wait = 1'b1;
    drive_id(1'b1, 4'd3, 4'd3, 1'b1, 1'b1, 4'd3, 2'b11);
    #1;
    checks++;
    if ({stl, fl, hz.fwd_a, hz.fwd_b} !== 10'd0) begin
      failures++;
      $display("FAIL rst_ctrl got=%b exp=0", {stl, fl, hz.fwd_a, hz.fwd_b});
    end
    checks++;
    if ({hz.stall_cnt, hz.flush_cnt} !== 32'd0) begin
      failures++;
      $display("FAIL rst_cnt got=%h exp=0", {hz.stall_cnt, hz.flush_cnt});
    end
    tick();
    rst_n = 1'b1;
    hz.mem_branch_taken = 1'b0;
    hz.mem_wait = 1'b0;
    drive_nop();
    #1;
    checks++;
    if ({stl, fl} !== 6'd0) begin
      failures++;
      $display("FAIL rst_idle got=%b exp=0", {stl, fl});
    end
    tick();
  endtask

  task automatic test_load_use();
    drive_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd3, 2'b11);
    tick();
    drive_id(1'b1, 4'd3, 4'd0, 1'b1, 1'b0, 4'd4, 2'b01);
    #1;
    checks++;
    if (stl !== 3'b111) begin
      failures++;
      $display("FAIL lu_stall got=%b exp=111", stl);
    end
    tick();
    #1;
    checks++;
    if (stl !== 3'b000) begin
      failures++;
      $display("FAIL lu_one_cycle got=%b exp=000", stl);
    end
    checks++;
    if (hz.stall_cnt !== 16'd1) begin
      failures++;
      $display("FAIL lu_cnt got=%0d exp=1", hz.stall_cnt);
    end
    tick();
    drive_nop();
    #1;
    checks++;
    if ({hz.fwd_a, hz.fwd_b} !== 4'b1000) begin
      failures++;
      $display("FAIL lu_fwd got=%b exp=1000", {hz.fwd_a, hz.fwd_b});
    end
    tick();
  endtask

  task automatic test_alu_fwd();
    drive_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd5, 2'b01);
    tick();
    drive_id(1'b1, 4'd0, 4'd5, 1'b0, 1'b1, 4'd6, 2'b01);
    #1;
    checks++;
    if (stl !== 3'b000) begin
      failures++;
      $display("FAIL alu_nostall got=%b exp=000", stl);
    end
    tick();
    drive_nop();
    #1;
    checks++;
    if (hz.fwd_b !== 2'b01) begin
      failures++;
      $display("FAIL alu_fwd_mem got=%b exp=01", hz.fwd_b);
    end
    tick();
    drive_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd5, 2'b01);
    tick();
    drive_id(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd7, 2'b01);
    tick();
    drive_id(1'b1, 4'd0, 4'd5, 1'b0, 1'b1, 4'd6, 2'b01);
    tick();
    drive_nop();
    #1;
    checks++;
    if ({hz.fwd_a, hz.fwd_b} !== 4'b0010) begin
      failures++;
      $display("FAIL alu_fwd_wb got=%b exp=0010", {hz.fwd_a, hz.fwd_b});
    end
    tick();
    drive_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd5, 2'b01);
    tick();
    drive_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd5, 2'b01);
    tick();
    drive_id(1'b1, 4'd0, 4'd5, 1'b0, 1'b1, 4'd6, 2'b01);
    tick();
    drive_nop();
    #1;
    checks++;
    if (hz.fwd_b !== 2'b01) begin
      failures++;
      $display("FAIL alu_fwd_prio got=%b exp=01", hz.fwd_b);
    end
    tick();
  endtask

  task automatic test_branch_load_use();
    reset_dut();
    drive_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd5, 2'b01);
    tick();
    drive_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd3, 2'b11);
    tick();
    drive_id(1'b1, 4'd3, 4'd5, 1'b1, 1'b1, 4'd4, 2'b01);
    hz.mem_branch_taken = 1'b1;
    #1;
    checks++;
    if ({fl, stl} !== 6'b111000) begin
      failures++;
      $display("FAIL br_flush got=%b exp=111000", {fl, stl});
    end
    tick();
    hz.mem_branch_taken = 1'b0;
    drive_nop();
    #1;
    checks++;
    if ({fl, stl} !== 6'b000000) begin
      failures++;
      $display("FAIL br_flush_state got=%b exp=000000", {fl, stl});
    end
    checks++;
    if ({hz.flush_cnt, hz.stall_cnt} !== {16'd1, 16'd0}) begin
      failures++;
      $display("FAIL br_cnt got=%h exp=00010000", {hz.flush_cnt, hz.stall_cnt});
    end
    tick();
    drive_id(1'b1, 4'd4, 4'd3, 1'b1, 1'b1, 4'd6, 2'b01);
    tick();
    drive_nop();
    #1;
    checks++;
    if ({hz.fwd_a, hz.fwd_b} !== 4'b0000) begin
      failures++;
      $display("FAIL br_killed got=%b exp=0000", {hz.fwd_a, hz.fwd_b});
    end
    tick();
  endtask

  task automatic test_mem_wait();
    drive_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd3, 2'b11);
    tick();
    drive_id(1'b1, 4'd0, 4'd3, 1'b0, 1'b1, 4'd4, 2'b01);
    hz.mem_wait = 1'b1;
    hz.mem_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({stl, fl} !== 6'b110000 || hz.stall_cnt !== 16'd0) begin
        failures++;
        $display("FAIL wait_freeze cyc=%0d got=%b cnt=%0d exp=110000 cnt=0", i, {stl, fl}, hz.stall_cnt);
      end
      tick();
    end
    hz.mem_wait = 1'b0;
    hz.mem_branch_taken = 1'b0;
    #1;
    checks++;
    if (stl !== 3'b111) begin
      failures++;
      $display("FAIL wait_release got=%b exp=111", stl);
    end
    tick();
    #1;
    checks++;
    if (stl !== 3'b000 || hz.stall_cnt !== 16'd1 || hz.flush_cnt !== 16'd1) begin
      failures++;
      $display("FAIL wait_after got=%b stall=%0d flush=%0d exp=000 1 1", stl, hz.stall_cnt, hz.flush_cnt);
    end
    tick();
    drive_nop();
    tick();
  endtask

  task automatic test_r0();
    drive_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 2'b01);
    tick();
    drive_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 2'b11);
    tick();
    drive_id(1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 4'd6, 2'b01);
    #1;
    checks++;
    if (stl !== 3'b000) begin
      failures++;
      $display("FAIL r0_nostall got=%b exp=000", stl);
    end
    tick();
    drive_nop();
    #1;
    checks++;
    if ({hz.fwd_a, hz.fwd_b} !== 4'b0000) begin
      failures++;
      $display("FAIL r0_fwd got=%b exp=0000", {hz.fwd_a, hz.fwd_b});
    end
    tick();
  endtask

  task automatic test_saturation();
    logic [15:0] exp_cnt [3];
    exp_cnt[0] = 16'hFFFE;
    exp_cnt[1] = 16'hFFFF;
    exp_cnt[2] = 16'hFFFF;
    force dut.stall_cnt_q = 16'hFFFD;
    tick();
    release dut.stall_cnt_q;
    for (int i = 0; i < 3; i++) begin
      drive_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd3, 2'b11);
      tick();
      drive_id(1'b1, 4'd3, 4'd0, 1'b1, 1'b0, 4'd4, 2'b01);
      tick();
      #1;
      checks++;
      if (hz.stall_cnt !== exp_cnt[i]) begin
        failures++;
        $display("FAIL sat_cnt step=%0d got=%h exp=%h", i, hz.stall_cnt, exp_cnt[i]);
      end
      tick();
    end
  endtask

  task automatic test_reset_abort();
    drive_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd3, 2'b11);
    tick();
    drive_id(1'b1, 4'd3, 4'd0, 1'b1, 1'b0, 4'd4, 2'b01);
    tick();
    hz.mem_branch_taken = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({stl, fl, hz.fwd_a, hz.fwd_b, hz.stall_cnt, hz.flush_cnt} !== 42'd0) begin
      failures++;
      $display("FAIL abort_stall got=%b %h %h exp=0", {stl, fl, hz.fwd_a, hz.fwd_b}, hz.stall_cnt, hz.flush_cnt);
    end
    tick();
    rst_n = 1'b1;
    hz.mem_branch_taken = 1'b0;
    drive_id(1'b1, 4'd3, 4'd3, 1'b1, 1'b1, 4'd4, 2'b01);
    #1;
    checks++;
    if ({stl, fl} !== 6'd0) begin
      failures++;
      $display("FAIL abort_stall_run got=%b exp=000000", {stl, fl});
    end
    tick();
    drive_nop();
    hz.mem_branch_taken = 1'b1;
    tick();
    hz.mem_branch_taken = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({fl, hz.flush_cnt} !== 19'd0) begin
      failures++;
      $display("FAIL abort_flush got=%b %h exp=0", fl, hz.flush_cnt);
    end
    tick();
    rst_n = 1'b1;
    hz.mem_branch_taken = 1'b1;
    #1;
    checks++;
    if (fl !== 3'b111) begin
      failures++;
      $display("FAIL abort_flush_run got=%b exp=111", fl);
    end
    tick();
    hz.mem_branch_taken = 1'b0;
    #1;
    checks++;
    if (hz.flush_cnt !== 16'd1) begin
      failures++;
      $display("FAIL abort_flush_cnt got=%0d exp=1", hz.flush_cnt);
    end
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_load_use();
    test_alu_fwd();
    test_branch_load_use();
    test_mem_wait();
    test_r0();
    test_saturation();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have these ports (name direction width meaning):
  clk  in  1  single clock, all state updates on rising edge
  rst_n  in  1  asynchronous, active-low reset
  id_valid  in  1  ID stage holds a real instruction
  id_rs  in  4  ID source register A
  id_rt  in  4  ID source register B
  id_use_rs  in  1  ID instruction reads id_rs
  id_use_rt  in  1  ID instruction reads id_rt
  id_rd  in  4  ID destination register
  id_wb  in  2  ID WB control: [1] MemToReg, [0] RegWrite (decoder WB field encoding)
  mem_branch_taken  in  1  MEM-stage BNE/jump resolved taken this cycle
  mem_wait  in  1  data memory not ready; whole pipeline frozen
  pc_stall  out  1  hold PC
  ifid_stall  out  1  hold IF/ID register
  idex_bubble  out  1  load zeros (NOP) into ID/EX
  flush_ifid  out  1  clear IF/ID
  flush_idex  out  1  clear ID/EX
  flush_exmem  out  1  clear EX/MEM
  fwd_a  out  2  EX operand A source: 00 regfile, 01 EX/MEM, 10 MEM/WB
  fwd_b  out  2  EX operand B source, same encoding
  stall_cnt  out  16  load-use stall cycles, saturating
  flush_cnt  out  16  taken-branch flushes, saturating

Function
REQ-002 Block SHALL hold a scoreboard: EX entry {valid, rd, rs, rt, use_rs, use_rt, wb}, MEM entry {valid, rd, wb}, WB entry {valid, rd, wb}.
REQ-003 Register 0 SHALL never cause a hazard or a forward (compares with rd=0 are false).
REQ-004 Load-use hazard SHALL be: EX.valid & EX.wb=2'b11 & EX.rd!=0 & id_valid & ((id_use_rs & id_rs==EX.rd) | (id_use_rt & id_rt==EX.rd)).
REQ-005 FSM states SHALL be RUN, STALL, FLUSH; reset state RUN.
REQ-006 RUN: mem_branch_taken -> FLUSH; else load-use -> STALL; else stay RUN.
REQ-007 STALL SHALL last exactly one cycle, then RUN (or FLUSH if mem_branch_taken that cycle).
REQ-008 FLUSH SHALL last exactly one cycle; load-use detection and id_valid ignored in FLUSH; then RUN.
REQ-009 Outputs combinational from state/inputs: load-use in RUN -> pc_stall=ifid_stall=idex_bubble=1, same cycle.
REQ-010 mem_branch_taken (mem_wait=0) -> flush_ifid=flush_idex=flush_exmem=1 same cycle; branch overrides simultaneous load-use (no stall asserted).
REQ-011 Scoreboard edge update when mem_wait=0: normal -> EX<=ID fields (valid=id_valid), MEM<=EX, WB<=MEM; load-use -> EX<=invalid, MEM<=EX, WB<=MEM; branch taken -> EX<=invalid, MEM<=invalid, WB<=MEM.
REQ-012 mem_wait=1 SHALL freeze FSM, scoreboard and counters; pc_stall=ifid_stall=1, idex_bubble=0, all flushes 0; mem_branch_taken ignored until mem_wait=0.
REQ-013 fwd_a: 01 if MEM.valid & MEM.wb[0] & !MEM.wb[1] & MEM.rd==EX.rs & EX.use_rs & rd!=0; else 10 if WB.valid & WB.wb[0] & WB.rd==EX.rs & EX.use_rs & rd!=0; else 00. fwd_b same with rt; MEM match has priority.
REQ-014 stall_cnt SHALL increment once per load-use stall cycle, flush_cnt once per taken branch; both hold at 16'hFFFF.

Reset
REQ-015 rst_n low SHALL immediately clear all scoreboard valids, FSM to RUN, counters to 0; all outputs 0 while in reset.
REQ-016 Reset assertion mid-STALL or mid-FLUSH SHALL abort it; first cycle after release is RUN with empty scoreboard.

Verification
REQ-017 Load r3 (id_wb=11, rd=3) then ADD reading r3 -> one cycle pc_stall=ifid_stall=idex_bubble=1, stall_cnt=1, ADD in EX two cycles later sees fwd_a=10.
REQ-018 ALU writing r5 followed by reader of r5 on rt -> no stall, fwd_b=01; one unrelated instruction between -> fwd_b=10.
REQ-019 Load-use and mem_branch_taken same cycle -> flush_ifid/idex/exmem=1, no stall, flush_cnt=1, stall_cnt=0, EX and MEM entries invalid next cycle.
REQ-020 mem_wait held 3 cycles during load-use -> scoreboard/counters frozen, stall resolves one cycle after mem_wait drops.
REQ-021 Instruction with rd=0 and RegWrite followed by reader of r0 -> fwd=00, no stall.
REQ-022 Preload stall_cnt to 16'hFFFF via repeated stalls -> further stalls leave 16'hFFFF; rst_n pulse mid-STALL -> all outputs 0 immediately.
